// File: rtl/std_pkg.sv
// std_pkg: shared types and helpers for the std_* sequential library.
//   std_reset_seq_state_t : state encoding of std_reset_sequencer
//   std_max(a, b)         : larger of two ints, used for counter sizing
package std_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2,
    RUNNING = 2'd3
  } std_reset_seq_state_t;

  function automatic int std_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/std_reset_sync.sv
// std_reset_sync: reset-release synchronizer.
// Clears asynchronously when rst is low; once rst is high, shifts a 1 through
// SYNC_STAGES flops so the release reaches the clock domain metastability-safe.
//   clk    in  clock, rising edge
//   rst    in  asynchronous active-low reset
//   sync_o out last chain stage, high once SYNC_STAGES edges have seen rst high
module std_reset_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] chain_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) chain_q <= '0;
    else      chain_q <= {chain_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign sync_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/std_reset_sequencer.sv
// std_reset_sequencer: reset source for downstream sequential blocks.
// Asserts all outputs asynchronously on rst low, releases them synchronously:
// sync -> stretch for HOLD_CYCLES -> release bit 0, then one bit every
// STAGGER_CYCLES. A soft_req while RUNNING re-enters HOLD (warm reset).
//   clk        in  clock, rising edge
//   rst        in  asynchronous active-low reset
//   soft_req   in  warm-reset request, only honoured in RUNNING
//   rst_out_n  out sequenced active-low resets, bit 0 released first
//   rst_done   out high while RUNNING (all outputs released)
//   soft_busy  out high in every state except RUNNING
// All outputs are flops; nothing combinational reaches them from the inputs.
module std_reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4,
  parameter int NUM_OUTPUTS    = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   soft_req,
  output logic [NUM_OUTPUTS-1:0] rst_out_n,
  output logic                   rst_done,
  output logic                   soft_busy
);
  import std_pkg::*;

  localparam int CNT_MAX = std_max(HOLD_CYCLES, STAGGER_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(NUM_OUTPUTS + 1);

  localparam logic [CNT_W-1:0] CNT_TOP   = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_OUTPUTS - 1);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("std_reset_sequencer: SYNC_STAGES must be >= 2");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("std_reset_sequencer: HOLD_CYCLES must be >= 1");
    end
  endgenerate

  logic rst_sync;

  std_reset_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .sync_o (rst_sync)
  );

  std_reset_seq_state_t   state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_OUTPUTS-1:0] out_q, out_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   hold_step;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    out_d     = out_q;
    hold_step = 1'b0;
    cnt_inc   = (cnt_q == CNT_TOP) ? cnt_q : cnt_q + 1'b1;

    case (state_q)
      // HOLD is logically entered on the edge the last sync flop rises; the
      // first edge that can observe it is therefore already HOLD count 1, so
      // ASSERT performs that first hold step itself instead of idling a cycle.
      ASSERT:  if (rst_sync) hold_step = 1'b1;
      HOLD:    hold_step = 1'b1;
      RELEASE: begin
        if (cnt_inc == STAG_LAST) begin
          for (int i = 0; i < NUM_OUTPUTS; i++)
            if (IDX_W'(i) == idx_q) out_d[i] = 1'b1;
          cnt_d = '0;
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_IDX) state_d = RUNNING;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RUNNING: begin
        if (soft_req) begin
          out_d   = '0;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = HOLD;
        end
      end
      default: state_d = ASSERT;
    endcase

    if (hold_step) begin
      if (cnt_inc == HOLD_LAST) begin
        cnt_d = '0;
        // Single output or zero stagger: everything goes at hold expiry.
        if (STAGGER_CYCLES == 0 || NUM_OUTPUTS == 1) begin
          out_d   = '1;
          state_d = RUNNING;
        end else begin
          out_d[0] = 1'b1;
          idx_d    = IDX_W'(1);
          state_d  = RELEASE;
        end
      end else begin
        cnt_d   = cnt_inc;
        state_d = HOLD;
      end
    end

    // Status lags RUNNING entry by one edge but drops on the warm-reset edge.
    done_d = (state_q == RUNNING) && !soft_req;
    busy_d = !done_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign rst_out_n = out_q;
  assign rst_done  = done_q;
  assign soft_busy = busy_q;

endmodule
